// File: rtl/vc_sel_arb4.sv
// vc_sel_arb4: packet-granular round-robin selector for the 4 virtual
// channels of one router input port. It picks the VC whose request is
// offered to the switch allocator. Once a VC is picked, it stays selected
// until its tail flit is popped, so packets are never interleaved.
module vc_sel_arb4 #(
  parameter int NUM_VC         = 4,
  parameter int VC_INDEX_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_VC-1:0]         vc_req_valid,
  input  logic [NUM_VC-1:0]         vc_tail,
  input  logic                      sa_grant,
  output logic [VC_INDEX_WIDTH-1:0] sel,
  output logic                      sel_valid,
  output logic [NUM_VC-1:0]         vc_pop,
  output logic                      locked
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [VC_INDEX_WIDTH-1:0] sel_reg, sel_next;
  logic [VC_INDEX_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [NUM_VC-1:0]         other_req;  // requests excluding the selected VC
  logic                      pop_fire;

  // Returns the first set bit of vec, searching start, start+1, ... modulo
  // NUM_VC. Iterating from the farthest offset down lets the nearest one win.
  function automatic logic [VC_INDEX_WIDTH-1:0] first_from(
    input logic [NUM_VC-1:0]         vec,
    input logic [VC_INDEX_WIDTH-1:0] start
  );
    logic [VC_INDEX_WIDTH-1:0] result;
    int                        idx;
    result = start;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % NUM_VC;
      if (vec[idx]) result = VC_INDEX_WIDTH'(idx);
    end
    return result;
  endfunction

  assign locked    = (state_reg == LOCK);
  assign sel       = sel_reg;
  assign sel_valid = locked & vc_req_valid[sel_reg];
  // A grant only counts when a valid request is actually offered.
  assign pop_fire  = sa_grant & sel_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      assign vc_pop[gi]    = pop_fire & (sel_reg == VC_INDEX_WIDTH'(gi));
      assign other_req[gi] = vc_req_valid[gi] & (sel_reg != VC_INDEX_WIDTH'(gi));
    end
  endgenerate

  // Next-state: arbitrate from IDLE, or hand over straight to the next
  // waiting VC on a tail pop so back-to-back packets see no bubble.
  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|vc_req_valid) begin
          sel_next   = first_from(vc_req_valid, rr_ptr_reg);
          state_next = LOCK;
        end
      end
      LOCK: begin
        // Body-flit gaps (request low) and non-tail pops keep the lock.
        if (pop_fire && vc_tail[sel_reg]) begin
          rr_ptr_next = sel_reg + VC_INDEX_WIDTH'(1);
          if (|other_req) begin
            sel_next = first_from(other_req, sel_reg + VC_INDEX_WIDTH'(1));
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointer and selection registers; reset drops any held lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      sel_reg    <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: tb/tb_vc_sel_arb4.sv
// tb_vc_sel_arb4: directed scenarios plus randomized traffic, checked each
// cycle against a packet-level round-robin reference model.
module tb_vc_sel_arb4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] vc_req_valid = '0;
  logic [3:0] vc_tail = '0;
  logic       sa_grant = 1'b0;
  logic [1:0] sel;
  logic       sel_valid;
  logic [3:0] vc_pop;
  logic       locked;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which VC owns the port, whether a packet is in
  // progress, and where the next round-robin search starts.
  int m_locked = 0;
  int m_sel    = 0;
  int m_rr     = 0;

  vc_sel_arb4 dut (
    .clk          (clk),
    .reset        (reset),
    .vc_req_valid (vc_req_valid),
    .vc_tail      (vc_tail),
    .sa_grant     (sa_grant),
    .sel          (sel),
    .sel_valid    (sel_valid),
    .vc_pop       (vc_pop),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int first_waiting(input logic [3:0] req, input int start);
    for (int k = 0; k < 4; k++) begin
      if (req[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_locked = 0;
    m_sel    = 0;
    m_rr     = 0;
  endfunction

  // One clock of the packet-level rules, using the inputs seen at the edge.
  function automatic void model_step(input logic [3:0] req, input logic [3:0] tail,
                                     input logic grant);
    logic [3:0] others;
    if (m_locked == 0) begin
      if (req != 0) begin
        m_sel    = first_waiting(req, m_rr);
        m_locked = 1;
      end
    end else if (grant && req[m_sel] && tail[m_sel]) begin
      m_rr   = (m_sel + 1) % 4;
      others = req;
      others[m_sel] = 1'b0;
      if (others != 0) m_sel = first_waiting(others, m_rr);
      else m_locked = 0;
    end
  endfunction

  // Drive one cycle, compare all outputs with the model, then advance the
  // model across the rising edge. xsel >= 0 adds an explicit sel check.
  task automatic cycle(input logic [3:0] req, input logic [3:0] tail,
                       input logic grant, input int xsel, input string tag);
    int exp_valid;
    int exp_pop;
    @(negedge clk);
    vc_req_valid = req;
    vc_tail      = tail;
    sa_grant     = grant;
    #1;
    exp_valid = (m_locked != 0 && req[m_sel]) ? 1 : 0;
    exp_pop   = (grant && exp_valid != 0) ? (1 << m_sel) : 0;
    check({tag, ".locked"}, int'(locked), m_locked);
    check({tag, ".sel_valid"}, int'(sel_valid), exp_valid);
    check({tag, ".vc_pop"}, int'(vc_pop), exp_pop);
    if (m_locked != 0) check({tag, ".sel"}, int'(sel), m_sel);
    if (xsel >= 0) check({tag, ".sel_exp"}, int'(sel), xsel);
    @(posedge clk);
    model_step(req, tail, grant);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    vc_req_valid = '0;
    vc_tail      = '0;
    sa_grant     = 1'b0;
    #1;
    check("rst.sel", int'(sel), 0);
    check("rst.locked", int'(locked), 0);
    check("rst.sel_valid", int'(sel_valid), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Single-flit packet on VC2; pointer then sits at 3.
    do_reset();
    cycle(4'b0100, 4'b0000, 1'b0, -1, "r20_req");
    cycle(4'b0100, 4'b0100, 1'b1, 2, "r20_pop");
    cycle(4'b0000, 4'b0000, 1'b0, -1, "r20_idle");
    cycle(4'b1111, 4'b0000, 1'b0, -1, "r20_arb");
    cycle(4'b1111, 4'b0000, 1'b0, 3, "r20_rr3");

    // All VCs busy with single-flit packets: 0,1,2,3,0 with no bubble.
    do_reset();
    cycle(4'b1111, 4'b1111, 1'b1, -1, "r21_arb");
    for (int i = 0; i < 5; i++) cycle(4'b1111, 4'b1111, 1'b1, i % 4, $sformatf("r21_%0d", i));

    // 3-flit packet on VC1 with a 2-cycle gap while VC3 waits.
    do_reset();
    cycle(4'b1010, 4'b0000, 1'b0, -1, "r22_arb");
    cycle(4'b1010, 4'b0000, 1'b1, 1, "r22_head");
    cycle(4'b1000, 4'b0000, 1'b1, 1, "r22_gap0");
    cycle(4'b1000, 4'b0000, 1'b1, 1, "r22_gap1");
    cycle(4'b1010, 4'b0000, 1'b1, 1, "r22_body");
    cycle(4'b1010, 4'b0010, 1'b1, 1, "r22_tail");
    cycle(4'b1000, 4'b0000, 1'b0, 3, "r22_next");

    // Grant while nothing is offered in IDLE is ignored.
    do_reset();
    cycle(4'b0000, 4'b1111, 1'b1, -1, "r23_idle");
    cycle(4'b0000, 4'b1111, 1'b1, -1, "r23_idle2");

    // Asynchronous reset in the middle of a VC2 packet.
    do_reset();
    cycle(4'b0100, 4'b0000, 1'b0, -1, "r24_arb");
    cycle(4'b0100, 4'b0000, 1'b1, 2, "r24_head");
    @(negedge clk);
    vc_req_valid = 4'b0100;
    sa_grant     = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("r24.sel", int'(sel), 0);
    check("r24.sel_valid", int'(sel_valid), 0);
    check("r24.vc_pop", int'(vc_pop), 0);
    check("r24.locked", int'(locked), 0);
    model_reset();
    @(negedge clk);
    reset        = 1'b0;
    vc_req_valid = '0;
    sa_grant     = 1'b0;
    cycle(4'b0110, 4'b0000, 1'b0, -1, "r24_arb2");
    cycle(4'b0110, 4'b0000, 1'b0, 1, "r24_sel1");

    // Tail on VC3 with nothing else waiting: wraps to 0, VC3 re-picked.
    do_reset();
    cycle(4'b1000, 4'b0000, 1'b0, -1, "r25_arb");
    cycle(4'b1000, 4'b1000, 1'b1, 3, "r25_tail");
    cycle(4'b1000, 4'b0000, 1'b0, -1, "r25_idle");
    cycle(4'b1000, 4'b0000, 1'b0, 3, "r25_resel");
    cycle(4'b1111, 4'b1000, 1'b1, 3, "r25_tail2");
    cycle(4'b1111, 4'b0000, 1'b0, 0, "r25_wrap");

    // Randomized traffic: bursty requests, random tails and grants.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      logic [3:0] t;
      logic       g;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      t = 4'($urandom_range(0, 15));
      g = ($urandom_range(0, 3) != 0);
      cycle(r, t, g, -1, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vc_sel_arb4.md
VC_SEL_ARB4 -- requirements
Module: vc_sel_arb4

Interface
REQ-001 Parameters SHALL be:
  NUM_VC  4  number of virtual channels per input port (fixed at 4)
  VC_INDEX_WIDTH  2  width of sel
REQ-002 Ports SHALL be:
  clk  input  1  single clock, rising-edge
  reset  input  1  asynchronous, active-high reset
  vc_req_valid  input  NUM_VC  bit v=1: VC v holds a flit with a nonzero port request
  vc_tail  input  NUM_VC  bit v=1: front flit of VC v is a tail (single-flit packet = head+tail)
  sa_grant  input  1  switch allocator accepted the currently offered request this cycle
  sel  output  VC_INDEX_WIDTH  VC index driving the 4-to-1 request select mux
  sel_valid  output  1  offered request (VC sel) is valid
  vc_pop  output  NUM_VC  one-hot dequeue strobe to the VC buffers
  locked  output  1  arbiter is mid-packet on VC sel
REQ-003 The block SHALL use one clock domain; reset SHALL be asynchronous, active-high.

Function
REQ-004 State SHALL be IDLE or LOCK, plus a 2-bit round-robin pointer rr_ptr and registered sel.
REQ-005 locked SHALL equal (state==LOCK).
REQ-006 sel_valid SHALL be combinational: locked AND vc_req_valid[sel].
REQ-007 vc_pop SHALL be combinational: one-hot(sel) when sa_grant AND sel_valid, else 0.
REQ-008 sa_grant while sel_valid=0 SHALL be ignored (no pop, no state change).
REQ-009 IDLE: if vc_req_valid!=0, next edge SHALL load sel with first valid VC searching rr_ptr, rr_ptr+1, ... mod 4, and enter LOCK; else remain IDLE, sel unchanged.
REQ-010 Select latency from IDLE SHALL be 1 cycle: request valid in cycle N -> sel_valid=1 in cycle N+1 (if still valid).
REQ-011 LOCK, no pop: state and sel SHALL hold; vc_req_valid[sel] dropping (body flit not yet arrived) SHALL deassert sel_valid but SHALL NOT release the lock.
REQ-012 LOCK, pop of non-tail (vc_tail[sel]=0): state and sel SHALL hold.
REQ-013 LOCK, pop of tail (vc_tail[sel]=1): rr_ptr SHALL become sel+1 mod 4; mask = vc_req_valid with bit sel cleared; if mask!=0, sel SHALL load first set bit of mask searching from sel+1 mod 4 and state SHALL remain LOCK (no bubble); else state SHALL go IDLE.
REQ-014 Wrap-around: pointer/search arithmetic SHALL be modulo 4 (sel=3 tail -> rr_ptr=0).
REQ-015 vc_tail SHALL be sampled only on a pop; vc_tail on non-selected VCs SHALL be ignored.
REQ-016 No VC SHALL be granted a second packet while another VC with a valid request waits (packet-granular round-robin, max wait 3 packets).

Reset
REQ-017 On reset assertion, asynchronously: state=IDLE, rr_ptr=0, sel=0; hence sel_valid=0, vc_pop=0, locked=0.
REQ-018 Reset mid-packet SHALL discard the lock; after release the first arbitration SHALL start from VC 0.
REQ-019 First arbitration SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-020 Reset, then vc_req_valid=4'b0100 -> next cycle sel=2, sel_valid=1, locked=1; sa_grant with vc_tail=4'b0100 -> vc_pop=4'b0100, then IDLE, rr_ptr=3.
REQ-021 vc_req_valid=4'b1111 constant, every offered flit granted and tail -> sel sequence 0,1,2,3,0 on consecutive cycles, no bubble, vc_pop one-hot each cycle.
REQ-022 3-flit packet on VC1 while VC3 valid; vc_req_valid[1] low for 2 cycles after head pop -> sel stays 1, sel_valid=0 during gap, VC3 not selected until VC1 tail pop, then sel=3 next cycle.
REQ-023 sa_grant=1 with sel_valid=0 (IDLE and mid-packet gap) -> vc_pop=0, state unchanged.
REQ-024 Reset asserted asynchronously mid-packet on VC2 -> outputs zero immediately; after release with vc_req_valid=4'b0110 -> sel=1.
REQ-025 Tail pop on sel=3 with vc_req_valid=4'b1000 only -> IDLE, rr_ptr=0; VC3 re-selected after 1 idle cycle if still valid.
